// File: rtl/ald_multi_precursor_sequencer.sv
// ALD cycle sequencer: steps each precursor channel through pulse/wait/vacuum
// phases for a programmed number of cycles, with interlock fault and abort.
module ald_multi_precursor_sequencer #(
   parameter int NUM_PREC = 2,
   parameter int TIME_W   = 32,
   parameter int CYC_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       ilk_ok,
   input  logic [NUM_PREC*TIME_W-1:0] cfg_pulse,
   input  logic [NUM_PREC*TIME_W-1:0] cfg_wait,
   input  logic [NUM_PREC*TIME_W-1:0] cfg_vac,
   input  logic [CYC_W-1:0]           cfg_cycles,
   output logic [NUM_PREC-1:0]        prec_valve,
   output logic                       vac_valve,
   output logic                       busy,
   output logic                       done,
   output logic                       fault,
   output logic [CYC_W-1:0]           cycle_cnt,
   output logic [2:0]                 chan_idx,
   output logic [2:0]                 phase
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PULSE = 3'd1,
      S_WAIT  = 3'd2,
      S_VAC   = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

   state_t                     state, nxt_state;
   logic                       start_q;
   logic [TIME_W-1:0]          timer, nxt_timer, timer_inc, cur_dur;
   logic [NUM_PREC*TIME_W-1:0] snap_pulse, snap_wait, snap_vac;
   logic [CYC_W-1:0]           snap_cycles, nxt_cyc, cyc_inc;
   logic [2:0]                 nxt_chan;
   logic [NUM_PREC-1:0]        nxt_onehot;
   logic                       start_rise, run_state, timed_state, expired, load;

   assign phase       = state;
   assign start_rise  = start & ~start_q;
   assign run_state   = (state == S_PULSE) || (state == S_WAIT) ||
                        (state == S_VAC)   || (state == S_NEXT);
   assign timed_state = (state == S_PULSE) || (state == S_WAIT) || (state == S_VAC);
   assign timer_inc   = timer + 1'b1;
   assign cyc_inc     = cycle_cnt + 1'b1;

   // Duration of the current phase for the active channel, from the snapshot.
   always_comb begin
      cur_dur = '0;
      for (int c = 0; c < NUM_PREC; c++) begin
         if (chan_idx == 3'(c)) begin
            case (state)
               S_PULSE: cur_dur = snap_pulse[c*TIME_W +: TIME_W];
               S_WAIT:  cur_dur = snap_wait[c*TIME_W +: TIME_W];
               S_VAC:   cur_dur = snap_vac[c*TIME_W +: TIME_W];
               default: cur_dur = '0;
            endcase
         end
      end
   end

   // Zero duration leaves after one clk; otherwise leave on the D-th tick.
   assign expired = (cur_dur == '0) || (tick && (timer_inc == cur_dur));

   always_comb begin
      nxt_state = state;
      nxt_cyc   = cycle_cnt;
      nxt_chan  = chan_idx;
      load      = 1'b0;
      if (run_state && !ilk_ok) begin
         nxt_state = S_FAULT;
      end else if (run_state && stop) begin
         nxt_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (stop && state == S_DONE) begin
                  nxt_state = S_IDLE;
               end else if (start_rise && ilk_ok && !stop) begin
                  load      = 1'b1;
                  nxt_cyc   = '0;
                  nxt_chan  = 3'd0;
                  nxt_state = (cfg_cycles == '0) ? S_DONE : S_PULSE;
               end
            end
            S_PULSE: if (expired) nxt_state = S_WAIT;
            S_WAIT:  if (expired) nxt_state = S_VAC;
            S_VAC:   if (expired) nxt_state = S_NEXT;
            S_NEXT: begin
               if (chan_idx < 3'(NUM_PREC - 1)) begin
                  nxt_chan  = chan_idx + 3'd1;
                  nxt_state = S_PULSE;
               end else begin
                  nxt_chan  = 3'd0;
                  nxt_cyc   = cyc_inc;
                  nxt_state = (cyc_inc == snap_cycles) ? S_DONE : S_PULSE;
               end
            end
            S_FAULT: if (stop && ilk_ok) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      if (nxt_state != state)      nxt_timer = '0;
      else if (tick && timed_state) nxt_timer = timer_inc;
      else                          nxt_timer = timer;
   end

   always_comb begin
      nxt_onehot = '0;
      for (int c = 0; c < NUM_PREC; c++) nxt_onehot[c] = (nxt_chan == 3'(c));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         start_q <= 1'b0;
         timer <= '0;
         snap_pulse <= '0;
         snap_wait <= '0;
         snap_vac <= '0;
         snap_cycles <= '0;
         cycle_cnt <= '0;
         chan_idx <= 3'd0;
         prec_valve <= '0;
         vac_valve <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= nxt_state;
         start_q <= start;
         timer <= nxt_timer;
         if (load) begin
            snap_pulse <= cfg_pulse;
            snap_wait <= cfg_wait;
            snap_vac <= cfg_vac;
            snap_cycles <= cfg_cycles;
         end
         cycle_cnt <= nxt_cyc;
         chan_idx <= nxt_chan;
         // Outputs follow the state being entered so they line up with phase.
         prec_valve <= (nxt_state == S_PULSE) ? nxt_onehot : '0;
         vac_valve <= (nxt_state == S_VAC);
         busy <= (nxt_state == S_PULSE) || (nxt_state == S_WAIT) ||
                 (nxt_state == S_VAC) || (nxt_state == S_NEXT);
         done <= (nxt_state == S_DONE);
         fault <= (nxt_state == S_FAULT);
      end
   end

endmodule

// File: tb/tb_ald_multi_precursor_sequencer.sv
// Directed bench for the ALD sequencer: nominal run, zero durations, snapshot,
// interlock fault, abort, zero cycles, held start and async reset.
module tb_ald_multi_precursor_sequencer;

   localparam int NP = 2;
   localparam int TW = 32;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst, tick, start, stop, ilk_ok;
   logic [NP*TW-1:0] cfg_pulse, cfg_wait, cfg_vac;
   logic [CW-1:0]   cfg_cycles;
   logic [NP-1:0]   prec_valve;
   logic            vac_valve, busy, done, fault;
   logic [CW-1:0]   cycle_cnt;
   logic [2:0]      chan_idx, phase;

   int n_assert = 0;
   int n_fail   = 0;
   bit tick_sparse = 1'b0;
   int tick_div = 0;

   ald_multi_precursor_sequencer #(.NUM_PREC(NP), .TIME_W(TW), .CYC_W(CW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .ilk_ok(ilk_ok),
      .cfg_pulse(cfg_pulse), .cfg_wait(cfg_wait), .cfg_vac(cfg_vac), .cfg_cycles(cfg_cycles),
      .prec_valve(prec_valve), .vac_valve(vac_valve), .busy(busy), .done(done),
      .fault(fault), .cycle_cnt(cycle_cnt), .chan_idx(chan_idx), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input int p0, p1, w0, w1, v0, v1, cyc);
      cfg_pulse  = {TW'(p1), TW'(p0)};
      cfg_wait   = {TW'(w1), TW'(w0)};
      cfg_vac    = {TW'(v1), TW'(v0)};
      cfg_cycles = CW'(cyc);
   endtask

   // Leaves the bench one clk after the accepting edge, start still high.
   task automatic launch();
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
   endtask

   task automatic wait_phase(input logic [2:0] p, input int bound, input string tag);
      int n = 0;
      while (phase !== p && n < bound) begin
         step(1);
         n++;
      end
      check(tag, 32'(phase), 32'(p));
   endtask

   task automatic count_pulse(output int n);
      n = 0;
      while (phase === 3'd1 && n < 200) begin
         n++;
         step(1);
      end
   endtask

   // Tick source: every clk, or every third clk when sparse.
   initial begin
      tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tick_sparse) begin
            tick_div = (tick_div + 1) % 3;
            tick = (tick_div == 0);
         end else begin
            tick = 1'b1;
         end
      end
   end

   // Valve exclusivity on every clk.
   always @(negedge clk) begin
      if (rst === 1'b1) check("valve_exclusive", 32'($countones({prec_valve, vac_valve}) <= 1), 32'd1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ph[15];
      int exp_pv[15];
      int n, p0_clks, next_visits, g;
      bit found;
      exp_ph = '{1, 1, 1, 2, 3, 3, 4, 1, 1, 2, 3, 3, 3, 3, 4};
      exp_pv = '{1, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0};

      rst = 1'b0; start = 1'b0; stop = 1'b0; ilk_ok = 1'b1;
      set_cfg(3, 2, 1, 1, 2, 4, 2);
      step(2);
      check("reset_phase", 32'(phase), 0);
      check("reset_outputs", 32'({prec_valve, vac_valve, busy, done, fault}), 0);
      check("reset_cycle_cnt", 32'(cycle_cnt), 0);
      rst = 1'b1;
      step(1);

      // Nominal two-cycle run.
      launch();
      for (int i = 0; i < 15; i++) begin
         check($sformatf("nom_phase_%0d", i), 32'(phase), 32'(exp_ph[i]));
         check($sformatf("nom_prec_%0d", i), 32'(prec_valve), 32'(exp_pv[i]));
         check($sformatf("nom_vac_%0d", i), 32'(vac_valve), 32'(exp_ph[i] == 3));
         check($sformatf("nom_busy_%0d", i), 32'(busy), 1);
         step(1);
      end
      check("nom_cycle1_phase", 32'(phase), 1);
      check("nom_cycle1_cnt", 32'(cycle_cnt), 1);
      check("nom_cycle1_chan", 32'(chan_idx), 0);
      step(15);
      check("nom_done_phase", 32'(phase), 5);
      check("nom_done", 32'(done), 1);
      check("nom_done_busy", 32'(busy), 0);
      check("nom_done_cnt", 32'(cycle_cnt), 2);
      step(5);
      check("nom_done_held", 32'(done), 1);

      // Zero durations.
      set_cfg(0, 1, 0, 0, 1, 1, 1);
      launch();
      p0_clks = 0;
      next_visits = 0;
      for (int i = 0; i < 8; i++) begin
         if (prec_valve === 2'b01) p0_clks++;
         if (phase === 3'd4) next_visits++;
         step(1);
      end
      check("zero_prec0_clks", 32'(p0_clks), 1);
      check("zero_next_visits", 32'(next_visits), 2);
      check("zero_done", 32'(done), 1);
      check("zero_cnt", 32'(cycle_cnt), 1);

      // Config snapshot.
      set_cfg(5, 5, 1, 1, 1, 1, 1);
      launch();
      cfg_pulse = {TW'(50), TW'(50)};
      count_pulse(n);
      check("snap_first_pulse", 32'(n), 5);
      wait_phase(3'd5, 100, "snap_first_done");
      launch();
      count_pulse(n);
      check("snap_second_pulse", 32'(n), 50);
      wait_phase(3'd5, 300, "snap_second_done");

      // Sparse tick: a 2-tick pulse spans 4..6 clks at one tick per 3 clks.
      set_cfg(2, 2, 1, 1, 1, 1, 1);
      tick_sparse = 1'b1;
      launch();
      count_pulse(n);
      check("sparse_pulse_range", 32'(n >= 4 && n <= 6), 1);
      wait_phase(3'd5, 100, "sparse_done");
      tick_sparse = 1'b0;

      // Interlock drop during channel 1 pulse of cycle 3.
      set_cfg(3, 2, 1, 1, 2, 4, 5);
      launch();
      found = 1'b0;
      for (g = 0; g < 200 && !found; g++) begin
         if (cycle_cnt === 16'd2 && chan_idx === 3'd1 && phase === 3'd1) found = 1'b1;
         else step(1);
      end
      check("ilk_reach_point", 32'(found), 1);
      ilk_ok = 1'b0;
      step(1);
      check("ilk_phase", 32'(phase), 6);
      check("ilk_fault", 32'(fault), 1);
      check("ilk_valves", 32'({prec_valve, vac_valve}), 0);
      check("ilk_busy", 32'(busy), 0);
      check("ilk_cnt", 32'(cycle_cnt), 2);
      check("ilk_chan", 32'(chan_idx), 1);
      start = 1'b0;
      step(1);
      ilk_ok = 1'b1;
      start = 1'b1;
      step(2);
      check("ilk_start_ignored", 32'(phase), 6);
      check("ilk_fault_sticky", 32'(fault), 1);
      stop = 1'b1;
      step(1);
      check("ilk_clear_phase", 32'(phase), 0);
      check("ilk_clear_fault", 32'(fault), 0);
      stop = 1'b0;

      // Abort during VAC of cycle 2.
      set_cfg(3, 2, 1, 1, 2, 4, 2);
      launch();
      found = 1'b0;
      for (g = 0; g < 100 && !found; g++) begin
         if (cycle_cnt === 16'd1 && phase === 3'd3) found = 1'b1;
         else step(1);
      end
      check("abort_reach_vac", 32'(found), 1);
      stop = 1'b1;
      step(1);
      check("abort_phase", 32'(phase), 0);
      check("abort_vac", 32'(vac_valve), 0);
      check("abort_busy_done", 32'({busy, done}), 0);
      check("abort_cnt_kept", 32'(cycle_cnt), 1);
      stop = 1'b0;
      launch();
      check("restart_phase", 32'(phase), 1);
      check("restart_chan", 32'(chan_idx), 0);
      check("restart_cnt", 32'(cycle_cnt), 0);
      check("restart_prec", 32'(prec_valve), 1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;

      // Zero cycles.
      set_cfg(3, 2, 1, 1, 2, 4, 0);
      launch();
      check("zcyc_phase", 32'(phase), 5);
      check("zcyc_done", 32'(done), 1);
      check("zcyc_busy", 32'(busy), 0);
      check("zcyc_cnt", 32'(cycle_cnt), 0);

      // Start held high launches one run only.
      set_cfg(1, 1, 1, 1, 1, 1, 1);
      launch();
      wait_phase(3'd5, 50, "held_done");
      step(20);
      check("held_no_relaunch", 32'(phase), 5);
      check("held_cnt", 32'(cycle_cnt), 1);

      // Async reset in the middle of a cycle-2 pulse.
      set_cfg(3, 2, 1, 1, 2, 4, 3);
      launch();
      found = 1'b0;
      for (g = 0; g < 100 && !found; g++) begin
         if (cycle_cnt === 16'd1 && phase === 3'd1) found = 1'b1;
         else step(1);
      end
      check("rst_reach_pulse", 32'(found), 1);
      start = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("arst_phase", 32'(phase), 0);
      check("arst_outputs", 32'({prec_valve, vac_valve, busy, done, fault}), 0);
      check("arst_cnt_chan", 32'({cycle_cnt, chan_idx}), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(2);
      check("post_rst_idle", 32'(phase), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
